cmd_dispatch16: RTL and testbench
=================================

CMD_DISPATCH16 -- requirements
Module: cmd_dispatch16

Interface
REQ-001 Parameter: TIMEOUT, default 8, legal range 1..255; number of WAIT_ACK clock edges allowed before the sensor must confirm.
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 m  input  1  master switch; sampled only at command accept; 1 = broadcast the value to all 16 channels.
REQ-005 cmd_valid  input  1  a command is offered.
REQ-006 cmd_ready  output  1  dispatcher can accept a command.
REQ-007 cmd_addr  input  4  target channel, 0 = channel a ... 15 = channel p.
REQ-008 cmd_val  input  2  2-bit switch value to drive.
REQ-009 s  input  16  confirmation sensors; s[n] belongs to channel n.
REQ-010 y  output  32  registered channel drives, packed: y[2n+1:2n] = channel n.
REQ-011 done  output  1  one-cycle pulse; command completed.
REQ-012 err  output  1  one-cycle pulse; command timed out.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, WAIT_ACK, DONE and ERR; done, err and cmd_ready SHALL be Moore decodes of the state.
REQ-014 cmd_ready SHALL be 1 only in IDLE; the accept condition is cmd_valid=1 and cmd_ready=1 at a rising edge.
REQ-015 Accept with m=0 at edge k: y[2a+1:2a] <= cmd_val; latch addr, the previous channel value and cmd_val; cnt <= 0; state -> WAIT_ACK.
REQ-016 Accept with m=1 at edge k: all 16 y fields <= cmd_val; state -> DONE; no sensor wait.
REQ-017 In WAIT_ACK: s[latched addr]=1 -> DONE; else if cnt==TIMEOUT-1 -> ERR; else cnt <= cnt+1.
REQ-018 When the ack and the timeout occur on the same edge, the ack SHALL win (-> DONE).
REQ-019 With the sensor already high at accept, done SHALL be high in the cycle after edge k+1, and cmd_ready SHALL be high again after edge k+2.
REQ-020 On a timeout, err SHALL be high in the cycle after edge k+TIMEOUT.
REQ-021 DONE and ERR SHALL each last exactly one cycle and then return to IDLE unconditionally.
REQ-022 Changes to m, cmd_addr, cmd_val or s[other channels] after accept SHALL have no effect on the command in progress.
REQ-023 y fields not addressed by the current command SHALL hold their values.
REQ-024 cnt SHALL be 8 bits wide and SHALL never wrap; TIMEOUT=1 means ERR at the first edge in WAIT_ACK that has no ack.

Reset
REQ-025 rst_n=0 SHALL immediately force: state=IDLE, y=32'h0, cnt=0, done=0, err=0 and cmd_ready=1 (cmd_ready=1 while rst_n=0 and after release).
REQ-026 A reset asserted mid-command SHALL abort the command with no done/err pulse and with y cleared.
REQ-027 After rst_n deasserts, the first accept SHALL be possible at the first rising edge.

Configuration
REQ-028 Macro CMD_ROLLBACK_EN, when defined: on entry to ERR, the addressed y field SHALL be restored to the value latched at accept.
REQ-029 Without CMD_ROLLBACK_EN: on ERR, the addressed y field SHALL keep the new cmd_val; only err signals the failure.

Verification
REQ-030 Reset, then accept addr=3, val=2'b10, m=0, with s[3]=1 held -> y[7:6]=10 after edge k; done high cycle k+2; all other y fields 0.
REQ-031 TIMEOUT=4, addr=5, val=01, s=0 -> err high after edge k+4; y[11:10]=00 with CMD_ROLLBACK_EN, 01 without it; done never pulses.
REQ-032 m=1, val=11 -> y=32'hFFFF_FFFF after edge k; done pulses next cycle; s ignored.
REQ-033 TIMEOUT=4, s[5] rises at the same edge that cnt reaches 3 -> done pulses and err does not.
REQ-034 Assert rst_n=0 during WAIT_ACK -> y=0 and state IDLE immediately with no clock; no done/err; a new command is accepted at the first edge after release.
REQ-035 Hold cmd_valid=1 during a command with cmd_addr/cmd_val changing -> second command accepted only when cmd_ready=1; the first command's result is unaffected.

Source files
------------

// File: rtl/cmd_dispatch16.sv
// cmd_dispatch16: single-command dispatcher for 16 two-bit switch channels.
//
// A command writes a 2-bit value to one channel, or to all 16 channels when
// m=1 (broadcast). A single-channel command then waits for its confirmation
// sensor. If the sensor does not confirm within TIMEOUT edges, the command
// ends in ERR.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   m          broadcast select, sampled only when a command is accepted
//   cmd_valid  a command is offered
//   cmd_ready  dispatcher is idle and can accept a command
//   cmd_addr   target channel (0..15)
//   cmd_val    2-bit value to drive
//   s          confirmation sensors; s[n] belongs to channel n
//   y          registered channel drives; y[2n+1:2n] holds channel n
//   done       one-cycle pulse when a command completes
//   err        one-cycle pulse when a command times out
//
// Parameter:
//   TIMEOUT    number of WAIT_ACK edges allowed before confirmation (1..255)
//
// Configuration macro:
//   CMD_ROLLBACK_EN  when defined, a timed-out command restores the addressed
//                    channel to the value it held before the command
module cmd_dispatch16 #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_addr,
  input  logic [1:0]  cmd_val,
  input  logic [15:0] s,
  output logic [31:0] y,
  output logic        done,
  output logic        err
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_ACK = 2'd1;
  localparam logic [1:0] ST_DONE     = 2'd2;
  localparam logic [1:0] ST_ERR      = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [3:0]       addr_q;
  logic [3:0]       addr_next;
  logic [31:0]      y_next;
  logic             ack_c;
  logic             expire_c;
`ifdef CMD_ROLLBACK_EN
  logic [1:0]       prev_q;
  logic [1:0]       prev_next;
`else
  logic [1:0]       val_q;
  logic [1:0]       val_next;
`endif

  // Moore decodes of the state register.
  assign cmd_ready = (state == ST_IDLE);
  assign done      = (state == ST_DONE);
  assign err       = (state == ST_ERR);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers: channel drives, wait counter and command latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y      <= 32'h0;
      cnt    <= '0;
      addr_q <= 4'h0;
`ifdef CMD_ROLLBACK_EN
      prev_q <= 2'b00;
`else
      val_q  <= 2'b00;
`endif
    end else begin
      y      <= y_next;
      cnt    <= cnt_next;
      addr_q <= addr_next;
`ifdef CMD_ROLLBACK_EN
      prev_q <= prev_next;
`else
      val_q  <= val_next;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    addr_next  = addr_q;
    y_next     = y;
`ifdef CMD_ROLLBACK_EN
    prev_next  = prev_q;
`else
    val_next   = val_q;
`endif
    // Only the latched channel's sensor matters once the command is in flight.
    ack_c      = s[addr_q];
    expire_c   = (cnt == CNT_LAST);

    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (m) begin
            // Broadcast needs no confirmation.
            y_next     = {16{cmd_val}};
            state_next = ST_DONE;
          end else begin
            y_next[{cmd_addr, 1'b0} +: 2] = cmd_val;
            addr_next  = cmd_addr;
`ifdef CMD_ROLLBACK_EN
            prev_next  = y[{cmd_addr, 1'b0} +: 2];
`else
            val_next   = cmd_val;
`endif
            cnt_next   = '0;
            state_next = ST_WAIT_ACK;
          end
        end
      end

      ST_WAIT_ACK: begin
        // A confirmation on the last allowed edge still counts as success.
        if (ack_c) begin
          state_next = ST_DONE;
        end else if (expire_c) begin
          state_next = ST_ERR;
`ifdef CMD_ROLLBACK_EN
          y_next[{addr_q, 1'b0} +: 2] = prev_q;
`else
          y_next[{addr_q, 1'b0} +: 2] = val_q;
`endif
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      ST_DONE, ST_ERR: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cmd_dispatch16.sv
// Randomized self-checking bench for cmd_dispatch16 (TIMEOUT=4). A per-channel
// array model tracks the expected drives and the expected result timing.
module tb_cmd_dispatch16;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_addr;
  logic [1:0]  cmd_val;
  logic [15:0] s;
  logic [31:0] y;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic [1:0] ref_y [16];

  always #5 clk = ~clk;

  cmd_dispatch16 #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m         (m),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_val   (cmd_val),
    .s         (s),
    .y         (y),
    .done      (done),
    .err       (err)
  );

  function automatic logic [31:0] ref_pack();
    logic [31:0] r;
    for (int n = 0; n < 16; n++) r[2*n +: 2] = ref_y[n];
    return r;
  endfunction

  // Runs one command from IDLE (called at a falling edge). ack_at is the
  // number of edges after accept from which s[a] is seen high (0 = already
  // high at accept). On return the DUT is back in IDLE at a falling edge.
  task automatic run_cmd(input logic [3:0] a, input logic [1:0] v,
                         input logic mm, input int ack_at, input bit hold,
                         input string tag);
    int waits;
    bit exp_err;
    logic [1:0] prev;
    logic [15:0] sv;
    if (mm) begin
      waits = 0; exp_err = 1'b0;
    end else if (ack_at <= int'(TMO)) begin
      waits = (ack_at < 1) ? 1 : ack_at; exp_err = 1'b0;
    end else begin
      waits = int'(TMO); exp_err = 1'b1;
    end

    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL %s ready_idle got=%b want=1", tag, cmd_ready);
    end
    cmd_valid = 1'b1; m = mm; cmd_addr = a; cmd_val = v;
    sv = 16'($urandom);
    sv[a] = (ack_at <= 0);
    s = sv;
    prev = ref_y[a];
    if (mm) begin
      for (int n = 0; n < 16; n++) ref_y[n] = v;
    end else begin
      ref_y[a] = v;
    end
    @(posedge clk); @(negedge clk);

    // Waiting cycles: inputs keep changing, nothing may leak into the command.
    for (int w = 0; w < waits; w++) begin
      total++;
      if (y !== ref_pack()) begin
        bad++; $display("FAIL %s wait%0d y got=%h want=%h", tag, w, y, ref_pack());
      end
      total++;
      if ({cmd_ready, done, err} !== 3'b000) begin
        bad++; $display("FAIL %s wait%0d rdy/done/err got=%b want=000", tag, w, {cmd_ready, done, err});
      end
      cmd_valid = 1'b1; m = 1'($urandom); cmd_addr = 4'($urandom); cmd_val = 2'($urandom);
      sv = 16'($urandom);
      sv[a] = ((w + 1) >= ack_at);
      s = sv;
      @(posedge clk); @(negedge clk);
    end

`ifdef CMD_ROLLBACK_EN
    if (exp_err) ref_y[a] = prev;
`endif
    total++;
    if ({done, err} !== {~exp_err, exp_err}) begin
      bad++; $display("FAIL %s result done/err got=%b want=%b", tag, {done, err}, {~exp_err, exp_err});
    end
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++; $display("FAIL %s result_ready got=%b want=0", tag, cmd_ready);
    end
    total++;
    if (y !== ref_pack()) begin
      bad++; $display("FAIL %s result y got=%h want=%h", tag, y, ref_pack());
    end
    cmd_valid = 1'b1; m = 1'($urandom); cmd_addr = 4'($urandom); cmd_val = 2'($urandom);
    s = 16'($urandom);
    @(posedge clk); @(negedge clk);

    total++;
    if ({cmd_ready, done, err} !== 3'b100) begin
      bad++; $display("FAIL %s back_idle rdy/done/err got=%b want=100", tag, {cmd_ready, done, err});
    end
    total++;
    if (y !== ref_pack()) begin
      bad++; $display("FAIL %s back_idle y got=%h want=%h", tag, y, ref_pack());
    end
    cmd_valid = hold;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m = 1'b0; cmd_valid = 1'b0; cmd_addr = 4'h0; cmd_val = 2'b00; s = 16'h0;
    for (int n = 0; n < 16; n++) ref_y[n] = 2'b00;
    #1;
    total++;
    if ({y, cmd_ready, done, err} !== {32'h0, 3'b100}) begin
      bad++; $display("FAIL reset_async got y=%h rdy/done/err=%b want y=0 100", y, {cmd_ready, done, err});
    end
    cmd_valid = 1'b1; cmd_val = 2'b11; m = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({y, cmd_ready, done, err} !== {32'h0, 3'b100}) begin
      bad++; $display("FAIL reset_held got y=%h rdy/done/err=%b want y=0 100", y, {cmd_ready, done, err});
    end
    cmd_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  // Sensor already high at accept: first accept right after release.
  task automatic test_sensor_ack();
    run_cmd(4'd3, 2'b10, 1'b0, 0, 1'b0, "ack_addr3");
    total++;
    if (y !== 32'h0000_0080) begin
      bad++; $display("FAIL ack_addr3_fields got=%h want=00000080", y);
    end
  endtask

  task automatic test_timeout();
    run_cmd(4'd5, 2'b01, 1'b0, 100, 1'b0, "timeout_addr5");
    total++;
`ifdef CMD_ROLLBACK_EN
    if (y[11:10] !== 2'b00) begin
      bad++; $display("FAIL timeout_rollback got=%b want=00", y[11:10]);
    end
`else
    if (y[11:10] !== 2'b01) begin
      bad++; $display("FAIL timeout_keep got=%b want=01", y[11:10]);
    end
`endif
  endtask

  task automatic test_broadcast();
    run_cmd(4'd7, 2'b11, 1'b1, 0, 1'b0, "broadcast11");
    total++;
    if (y !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL broadcast_all got=%h want=ffffffff", y);
    end
    run_cmd(4'd0, 2'b01, 1'b1, 0, 1'b0, "broadcast01");
  endtask

  // Ack on the last allowed edge beats the timeout; one edge later is an error.
  task automatic test_tie();
    run_cmd(4'd5, 2'b10, 1'b0, int'(TMO), 1'b0, "tie_ack_wins");
    run_cmd(4'd5, 2'b11, 1'b0, int'(TMO) + 1, 1'b0, "late_ack_err");
    run_cmd(4'd15, 2'b01, 1'b0, 1, 1'b0, "ack_first_edge");
  endtask

  // cmd_valid held high across consecutive commands with busy-time churn.
  task automatic test_back_to_back();
    run_cmd(4'd2, 2'b01, 1'b0, 2, 1'b1, "b2b_0");
    run_cmd(4'd9, 2'b10, 1'b0, 100, 1'b1, "b2b_1");
    run_cmd(4'd2, 2'b11, 1'b1, 0, 1'b1, "b2b_2");
    run_cmd(4'd14, 2'b00, 1'b0, 3, 1'b0, "b2b_3");
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1; m = 1'b0; cmd_addr = 4'd9; cmd_val = 2'b11; s = 16'h0;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    ref_y[9] = 2'b11;
    total++;
    if (y !== ref_pack()) begin
      bad++; $display("FAIL midrst_pre y got=%h want=%h", y, ref_pack());
    end
    @(posedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int n = 0; n < 16; n++) ref_y[n] = 2'b00;
    total++;
    if ({y, cmd_ready, done, err} !== {32'h0, 3'b100}) begin
      bad++; $display("FAIL midrst_abort got y=%h rdy/done/err=%b want y=0 100", y, {cmd_ready, done, err});
    end
    @(posedge clk); #1;
    total++;
    if ({done, err} !== 2'b00) begin
      bad++; $display("FAIL midrst_nopulse got=%b want=00", {done, err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(4'd6, 2'b10, 1'b0, 1, 1'b0, "after_midrst");
  endtask

  task automatic test_random();
    logic [3:0] a;
    logic [1:0] v;
    logic mm;
    int ack_at;
    for (int i = 0; i < 40; i++) begin
      a = 4'($urandom);
      v = 2'($urandom);
      mm = ($urandom_range(0, 3) == 0);
      ack_at = int'($urandom_range(0, TMO + 2));
      run_cmd(a, v, mm, ack_at, (i != 39), $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_sensor_ack();
    test_timeout();
    test_broadcast();
    test_tie();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
